// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the arbitrated ALU slice
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } op_code_t;

    typedef struct packed {
        logic z;
        logic n;
        logic ov;
        logic c;
    } alu_flags_t;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: shared N-bit ADD/SUB/AND/OR datapath with Z/N/V/C flags
module alu_core
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  op_code_t     i_op,
    output logic [N-1:0] o_r,
    output alu_flags_t   o_flags
);
    logic [N:0] w_sum;
    logic [N:0] w_dif;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
    assign w_dif = {1'b0, i_a} - {1'b0, i_b};

    // select result and derive flags; bit N of the difference is the borrow
    always_comb begin
        o_flags = '0;
        o_r = (i_op == OP_ADD) ? w_sum[N-1:0] :
              (i_op == OP_SUB) ? w_dif[N-1:0] :
              (i_op == OP_AND) ? (i_a & i_b) : (i_a | i_b);
        o_flags.c = (i_op == OP_ADD) ? w_sum[N] :
                    (i_op == OP_SUB) ? w_dif[N] : 1'b0;
        o_flags.ov = (i_op == OP_ADD) ? ((i_a[N-1] == i_b[N-1]) && (o_r[N-1] != i_a[N-1])) :
                     (i_op == OP_SUB) ? ((i_a[N-1] != i_b[N-1]) && (o_r[N-1] != i_a[N-1])) : 1'b0;
        o_flags.z = (o_r == '0);
        o_flags.n = o_r[N-1];
    end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at the pointer position
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx,
    output logic            o_found
);
    // scan from the farthest offset back to ptr so the nearest requester wins
    always_comb begin
        o_idx = '0;
        o_found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req[(int'(i_ptr) + k) % NREQ]) begin
                o_idx = IDW'((int'(i_ptr) + k) % NREQ);
                o_found = 1'b1;
            end
        end
        o_gnt = (i_en && o_found) ? ({{(NREQ-1){1'b0}}, 1'b1} << o_idx) : '0;
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin shared ALU with a single-entry registered response slot
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N    = 4,
    parameter int NREQ = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0][N-1:0]     req_a,
    input  logic [NREQ-1:0][N-1:0]     req_b,
    input  logic [NREQ-1:0][1:0]       req_op,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic [N-1:0]               rsp_rslt,
    output logic                       rsp_z,
    output logic                       rsp_n,
    output logic                       rsp_ov,
    output logic                       rsp_c
);
    localparam int IDW = $clog2(NREQ);

    slot_state_t      r_state;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_id;
    logic [N-1:0]     r_rslt;
    alu_flags_t       r_flags;

    logic             w_free;
    logic             w_en;
    logic             w_found;
    logic             w_acc;
    logic [IDW-1:0]   w_idx;
    logic [N-1:0]     w_r;
    alu_flags_t       w_flags;

    // slot can take a new op when empty or being drained; nothing is granted while in reset
    assign w_free = (r_state == ST_EMPTY) | rsp_ready;
    assign w_en   = w_free & rst_n;
    assign w_acc  = w_en & w_found;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .i_en    (w_en),
        .o_gnt   (req_ready),
        .o_idx   (w_idx),
        .o_found (w_found)
    );

    alu_core #(.N(N)) u_alu (
        .i_a     (req_a[w_idx]),
        .i_b     (req_b[w_idx]),
        .i_op    (op_code_t'(req_op[w_idx])),
        .o_r     (w_r),
        .o_flags (w_flags)
    );

    // slot FSM, round-robin pointer and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_ptr   <= '0;
            r_id    <= '0;
            r_rslt  <= '0;
            r_flags <= '0;
        end else if (w_acc) begin
            r_state <= ST_FULL;
            r_ptr   <= (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
            r_id    <= w_idx;
            r_rslt  <= w_r;
            r_flags <= w_flags;
        end else if (rsp_ready) begin
            r_state <= ST_EMPTY;
        end
    end

    assign rsp_valid = (r_state == ST_FULL);
    assign rsp_id    = r_id;
    assign rsp_rslt  = r_rslt;
    assign rsp_z     = r_flags.z;
    assign rsp_n     = r_flags.n;
    assign rsp_ov    = r_flags.ov;
    assign rsp_c     = r_flags.c;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks against a behavioural slot/round-robin model
module tb_alu_arbiter;
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       req_valid = '0;
    logic [3:0]       req_ready;
    logic [3:0][3:0]  req_a = '0;
    logic [3:0][3:0]  req_b = '0;
    logic [3:0][1:0]  req_op = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [1:0]       rsp_id;
    logic [3:0]       rsp_rslt;
    logic             rsp_z, rsp_n, rsp_ov, rsp_c;

    int n_cmp = 0;
    int n_err = 0;

    int m_full, m_ptr, m_id, m_rslt, m_z, m_n, m_ov, m_c;
    int last_w;
    logic [3:0] g_obs;
    int wait_cnt [4];

    alu_arbiter #(.N(4), .NREQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_rslt  (rsp_rslt),
        .rsp_z     (rsp_z),
        .rsp_n     (rsp_n),
        .rsp_ov    (rsp_ov),
        .rsp_c     (rsp_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // signed-range view of the four operations
    function automatic void ref_alu(input int a, input int b, input int op);
        int sa, sb, s;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        m_c = 0;
        m_ov = 0;
        if (op == 0) begin
            m_rslt = (a + b) % 16;
            m_c = (a + b >= 16) ? 1 : 0;
            s = sa + sb;
            m_ov = (s > 7 || s < -8) ? 1 : 0;
        end else if (op == 1) begin
            m_rslt = (a - b + 16) % 16;
            m_c = (a < b) ? 1 : 0;
            s = sa - sb;
            m_ov = (s > 7 || s < -8) ? 1 : 0;
        end else if (op == 2) begin
            m_rslt = a & b;
        end else begin
            m_rslt = a | b;
        end
        m_z = (m_rslt == 0) ? 1 : 0;
        m_n = (m_rslt >= 8) ? 1 : 0;
    endfunction

    function automatic void model_reset();
        m_full = 0; m_ptr = 0; m_id = 0; m_rslt = 0;
        m_z = 0; m_n = 0; m_ov = 0; m_c = 0;
    endfunction

    task automatic chk_reset_vals();
        chk("rst_valid", rsp_valid, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_rslt", rsp_rslt, 0);
        chk("rst_flags", {rsp_z, rsp_n, rsp_ov, rsp_c}, 0);
        chk("rst_ready", req_ready, 0);
    endtask

    // one clock: inputs are already set after a falling edge
    task automatic cycle();
        int w;
        #1;
        w = -1;
        if (m_full == 0 || rsp_ready) begin
            for (int k = 0; k < 4; k++)
                if (w < 0 && req_valid[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
        end
        g_obs = req_ready;
        chk("req_ready", req_ready, (w < 0) ? 0 : (1 << w));
        last_w = w;
        @(posedge clk);
        if (w >= 0) begin
            ref_alu(int'(req_a[w]), int'(req_b[w]), int'(req_op[w]));
            m_full = 1;
            m_id = w;
            m_ptr = (w + 1) % 4;
        end else if (rsp_ready) begin
            m_full = 0;
        end
        #1;
        chk("rsp_valid", rsp_valid, m_full);
        if (m_full != 0) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_rslt", rsp_rslt, m_rslt);
            chk("rsp_flags", {rsp_z, rsp_n, rsp_ov, rsp_c}, {m_z[0], m_n[0], m_ov[0], m_c[0]});
        end
        @(negedge clk);
    endtask

    task automatic chk_rsp(input string tag, input int id, input int r, input int z, input int n, input int ov, input int c);
        chk({tag, "_id"}, rsp_id, id);
        chk({tag, "_rslt"}, rsp_rslt, r);
        chk({tag, "_zn"}, {rsp_z, rsp_n}, {z[0], n[0]});
        chk({tag, "_vc"}, {rsp_ov, rsp_c}, {ov[0], c[0]});
    endtask

    task automatic set_req(input int i, input int a, input int b, input int op);
        req_a[i] = 4'(a);
        req_b[i] = 4'(b);
        req_op[i] = 2'(op);
    endtask

    initial begin
        int exp_seq [6];
        exp_seq = '{0, 1, 2, 3, 0, 1};
        model_reset();
        req_valid = 4'b1111;
        #1;
        chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b0010;

        set_req(1, 7, 1, 0);
        cycle();
        chk_rsp("add", 1, 8, 0, 1, 1, 0);
        set_req(1, 0, 1, 1);
        cycle();
        chk_rsp("sub0", 1, 15, 0, 1, 0, 1);
        set_req(1, 8, 1, 1);
        cycle();
        chk_rsp("sub8", 1, 7, 0, 0, 1, 0);
        set_req(1, 10, 5, 2);
        cycle();
        chk_rsp("and", 1, 0, 1, 0, 0, 0);
        set_req(1, 10, 5, 3);
        cycle();
        chk_rsp("or", 1, 15, 0, 1, 0, 0);

        req_valid = 4'b1000;
        set_req(3, 1, 1, 0);
        cycle();
        for (int i = 0; i < 4; i++) set_req(i, i + 3, i, i);
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("rr_grant", g_obs, 1 << exp_seq[k]);
            chk("rr_id", rsp_id, exp_seq[k]);
        end

        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("hold_grant", g_obs, 0);
            chk("hold_id", rsp_id, 1);
            chk("hold_valid", rsp_valid, 1);
        end
        rsp_ready = 1'b1;
        cycle();
        chk("drain_grant", g_obs, 4);
        chk("drain_id", rsp_id, 2);

        req_valid = 4'b0010;
        cycle();
        chk("pre_rst_id", rsp_id, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", rsp_valid, 0);
        chk("async_ready", req_ready, 0);
        model_reset();
        @(posedge clk);
        #1;
        chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b1001;
        set_req(0, 3, 4, 0);
        set_req(3, 9, 2, 1);
        cycle();
        chk("post_rst_grant", g_obs, 1);
        chk("post_rst_id", rsp_id, 0);

        req_valid = '0;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        cycle();
        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < 4; i++) begin
                if (!(req_valid[i] && i != last_w)) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    set_req(i, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (last_w >= 0) begin
                chk("starve", wait_cnt[last_w] < 4, 1);
                for (int i = 0; i < 4; i++)
                    if (i != last_w && req_valid[i]) wait_cnt[i]++;
                wait_cnt[last_w] = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one N-bit ALU (ADD/SUB/AND/OR with Z/N/V/C flags) between NREQ requesters. Fair round-robin arbitration, one accepted operation per cycle, result and flags held in a single-entry registered response slot with valid/ready backpressure. Sits between requester pipelines and the shared arithmetic datapath; the response is returned to one consumer, tagged with the requester ID.

## Interface
- N, 4, operand/result width (≥2)
- NREQ, 4, number of requesters (≥2); IDW = $clog2(NREQ)

- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_ready  out  NREQ  grant/accept, one-hot or zero
- req_a  in  NREQ×N  operand a per requester
- req_b  in  NREQ×N  operand b per requester
- req_op  in  NREQ×2  op code per requester: 0 ADD, 1 SUB, 2 AND, 3 OR
- rsp_valid  out  1  response slot full
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  IDW  requester index of held response
- rsp_rslt  out  N  result
- rsp_z, rsp_n, rsp_ov, rsp_c  out  1 each  flags

## Operation
- Slot FSM: EMPTY, FULL. EMPTY→FULL on accept. FULL→EMPTY on rsp_ready with no accept. FULL→FULL on rsp_ready with accept (same-cycle drain and refill). FULL with rsp_ready=0: hold; all outputs stable.
- free = (state==EMPTY) | rsp_ready. No grant when free=0.
- Round-robin: pointer ptr (IDW bits). Search order ptr, ptr+1, …, wrap mod NREQ; first i with req_valid[i] wins. req_ready[i]=1 only for the winner and only when free.
- Accept = req_valid[i] & req_ready[i]. On accept: ptr ← (i+1) mod NREQ (wraps NREQ−1→0). No accept: ptr unchanged.
- Winner's a, b, op muxed to ALU combinationally; result and flags captured into slot on accept edge with rsp_id ← i.
- Arithmetic, width N, carry = bit N of the (N+1)-bit sum/difference:
  - ADD: c = carry out; ov = sign(a)=sign(b)≠sign(r).
  - SUB: c = borrow (bit N of a−b); ov = sign(a)≠sign(b) & sign(r)≠sign(a).
  - AND/OR: c=0, ov=0.
  - z = (r==0); n = r[N−1].
- req_ready depends combinationally on req_valid; requesters must not make req_valid depend on req_ready. A requester holds a/b/op stable while valid and not accepted.

## Timing
- Reset (async assert, sync release): state EMPTY, rsp_valid=0, ptr=0, rsp_id=0, rsp_rslt=0, all flags 0, req_ready=0. Reset mid-operation drops the held response; in-flight requests are not accepted.
- Latency: accept at edge k → rsp_valid=1 and data valid after edge k.
- Throughput: one op per cycle with rsp_ready held 1.
- Starvation bound: a continuously valid requester is accepted within NREQ accepts.

## Structure
- Package alu_pkg: op_code_t enum (ADD=0, SUB=1, AND=2, OR=3), alu_flags_t packed struct {z, n, ov, c}, slot state enum.
- Sub-modules: the existing shared ALU instanced for the datapath; rr_arbiter (NREQ-wide request vector, ptr, en → one-hot grant, winner index) as a separate module.
- Slot register and FSM stay in alu_arbiter.

## Test plan
- N=4, NREQ=4. Requester 1 only, ADD a=7 b=1, rsp_ready=1 → accepted cycle 0; next cycle rsp_valid=1, rsp_id=1, rslt=8, n=1, ov=1, c=0, z=0.
- SUB a=0 b=1 → rslt=F, c=1, n=1, ov=0. SUB a=8 b=1 → rslt=7, ov=1, c=0, n=0.
- AND a=A b=5 → rslt=0, z=1, c=0, ov=0. OR a=A b=5 → rslt=F, n=1.
- All four req_valid held, rsp_ready=1 → grants 0,1,2,3,0,1 on consecutive cycles; rsp_id follows one cycle later.
- rsp_ready=0 with response held and requesters valid → req_ready=0000, rsp fields stable for 5 cycles. Then rsp_ready=1 → drain and next grant in the same cycle, with no bubble.
- rst_n low while rsp_valid=1, ptr=2 → rsp_valid=0 immediately without a clock edge. After release, requesters 0 and 3 valid → 0 granted first.
